scan_chain_ctrl: RTL
====================

# scan_chain_ctrl

Sequencer for one scan chain built from mux-D scan cells (SE-selected SI/D flip-flops). It accepts test patterns over a valid/ready stream, shifts each pattern into the chain and pulses one functional capture cycle. It shifts the captured response out while the next pattern shifts in, and returns responses over a second valid/ready stream. It sits between the PODEM pattern source and the scan-inserted circuit under test.

## Interface
- CHAIN_LEN, 8, number of scan cells in the chain (≥2)
- CNT_W, $clog2(CHAIN_LEN+1), shift counter width (derived, not overridden)
- C  input  1  clock; all state updates on rising edge; same clock as the scan cells
- RN  input  1  reset, asynchronous, active-low
- pat_valid  input  1  pattern available
- pat_ready  output  1  controller accepts pattern this cycle
- pat_data  input  CHAIN_LEN  pattern; bit i is loaded into cell i
- pat_last  input  1  final pattern; controller drains its response afterwards
- resp_valid  output  1  response available
- resp_ready  input  1  consumer takes response
- resp_data  output  CHAIN_LEN  captured response; bit i is from cell i
- SE  output  1  scan enable to all cells
- SI  output  1  scan-in to cell 0
- SO  input  1  Q of cell CHAIN_LEN-1
- busy  output  1  state ≠ IDLE
- cap_count  output  16  captures performed; wraps at 0xFFFF→0

## Operation
- Chain order: SI→cell 0→…→cell CHAIN_LEN-1→SO. Shift is MSB-first: SI = shreg[CHAIN_LEN-1], and shreg shifts left each SHIFT edge.
- Unload: at each SHIFT edge, SO is shifted into rxreg LSB. After CHAIN_LEN edges, rxreg[i] equals the value captured in cell i.
- States:
  - IDLE: SE=0, SI=0.
    - pat_ready = !resp_valid.
    - On pat_valid&&pat_ready: shreg←pat_data, last←pat_last, cnt←0, go to SHIFT.
    - If drain_pend && !resp_valid: cnt←0, shreg←0, go to DRAIN.
  - SHIFT: SE=1. After the CHAIN_LEN-th edge:
    - If have_resp: resp_data←rxreg (the final shifted value) and resp_valid←1.
    - Go to CAPTURE.
  - CAPTURE: SE=0 for exactly one cycle; the cells load D.
    - have_resp←1, cap_count+1.
    - If last: drain_pend←1. Go to IDLE.
  - DRAIN: SE=1, SI=0, shifting CHAIN_LEN edges. Then resp_data←rxreg, resp_valid←1, have_resp←0, drain_pend←0, go to IDLE.
- resp_valid clears on resp_valid&&resp_ready.
  - If that handshake coincides with SHIFT/DRAIN completion, the new response loads and resp_valid stays 1.
  - That coincidence cannot occur, because a shift never starts while resp_valid=1.
- Single-entry response buffer. Back-pressure is applied only by withholding pat_ready or DRAIN entry. The chain is never stalled mid-shift.
- The first pattern after reset or after a drain produces no response (have_resp=0). Its unload bits are discarded.
- pat_data and pat_last are sampled only on the accept edge.
- Reset (RN low, any time, including mid-shift):
  - state=IDLE; SE=0, SI=0.
  - resp_valid=0, resp_data=0, cap_count=0.
  - have_resp=0, drain_pend=0, last=0, cnt=0, shreg=0, rxreg=0.
  - Chain contents are undefined afterwards; the first pattern reloads them.

## Timing
- Accept edge → SE=1 in the next cycle. SHIFT lasts CHAIN_LEN cycles, then one CAPTURE cycle with SE=0, then ≥1 IDLE cycle.
- Minimum pattern period: CHAIN_LEN+2 cycles.
- Response of pattern n: resp_valid rises at the edge ending pattern n+1's SHIFT, or the edge ending DRAIN.
- SE and SI are decoded from registered state/shreg only. They are stable for the full cycle before each shift edge.
- pat_ready and busy are combinational from registered state and resp_valid. They have no combinational path from pat_valid or resp_ready.

## Test plan
Unless stated otherwise, the bench uses CHAIN_LEN=4 with a behavioural chain of 4 scan cells, D_i = ~Q_i.
- Reset: assert RN low mid-SHIFT → SE=0, resp_valid=0, cap_count=0, busy=0 immediately. After release, pat_ready=1.
- Load/capture: send 4'b1010 with pat_last=1.
  - SE is high for exactly 4 cycles, then low for 1.
  - DRAIN follows; resp_data=4'b0101 and resp_valid=1; cap_count=1.
- Overlap: send 4'b0011, 4'b1100, 4'b1111 back-to-back with last on the third. Responses must be 4'b1100, 4'b0011, 4'b0000 in order, with no response for a fourth slot.
- Back-pressure: hold resp_ready=0 after the first response → pat_ready stays 0 and SE stays 0. Releasing resp_ready for one cycle re-enables acceptance on the next cycle.
- Coverage: with CHAIN_LEN=8, random patterns checked against a reference model of ~pattern per captured word. The scenario ends with drain_pend set while resp_valid=1, which must delay DRAIN until the handshake completes.
- Wrap: preload scenario drives 65536 captures → cap_count reads 0.

Source files
------------

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: streams patterns into a mux-D scan chain, pulses one capture
// cycle, and returns each captured response while the next pattern shifts in.
module scan_chain_ctrl #(
   parameter  int CHAIN_LEN = 8,
   localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic                 C,
   input  logic                 RN,
   input  logic                 pat_valid,
   output logic                 pat_ready,
   input  logic [CHAIN_LEN-1:0] pat_data,
   input  logic                 pat_last,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [CHAIN_LEN-1:0] resp_data,
   output logic                 SE,
   output logic                 SI,
   input  logic                 SO,
   output logic                 busy,
   output logic [15:0]          cap_count
);

   typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, DRAIN} state_t;

   state_t               state, state_nxt;
   logic [CHAIN_LEN-1:0] shreg;
   logic [CHAIN_LEN-1:0] rxreg;
   logic [CHAIN_LEN-1:0] rx_nxt;
   logic [CNT_W-1:0]     cnt;
   logic                 last;
   logic                 have_resp;
   logic                 drain_pend;
   logic [15:0]          cap_q;
   logic                 accept;
   logic                 drain_go;
   logic                 shift_done;

   assign rx_nxt    = {rxreg[CHAIN_LEN-2:0], SO};
   assign cap_count = cap_q;

   always_comb begin
      state_nxt  = state;
      SE         = 1'b0;
      SI         = 1'b0;
      pat_ready  = 1'b0;
      accept     = 1'b0;
      drain_go   = 1'b0;
      shift_done = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            pat_ready = !resp_valid;
            if (pat_valid && !resp_valid) begin
               accept    = 1'b1;
               state_nxt = SHIFT;
            end else if (drain_pend && !resp_valid) begin
               drain_go  = 1'b1;
               state_nxt = DRAIN;
            end
         end
         SHIFT: begin
            SE         = 1'b1;
            SI         = shreg[CHAIN_LEN-1];
            shift_done = (cnt == CNT_W'(CHAIN_LEN - 1));
            if (shift_done) state_nxt = CAPTURE;
         end
         CAPTURE: state_nxt = IDLE;
         DRAIN: begin
            SE         = 1'b1;
            shift_done = (cnt == CNT_W'(CHAIN_LEN - 1));
            if (shift_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge C or negedge RN) begin
      if (!RN) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge C or negedge RN) begin
      if (!RN) begin
         resp_valid <= 1'b0;
         resp_data  <= '0;
         cap_q      <= '0;
         have_resp  <= 1'b0;
         drain_pend <= 1'b0;
         last       <= 1'b0;
         cnt        <= '0;
         shreg      <= '0;
         rxreg      <= '0;
      end else begin
         if (resp_valid && resp_ready) resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  shreg <= pat_data;
                  last  <= pat_last;
                  cnt   <= '0;
               end else if (drain_go) begin
                  shreg <= '0;
                  cnt   <= '0;
               end
            end
            SHIFT, DRAIN: begin
               shreg <= shreg << 1;
               rxreg <= rx_nxt;
               cnt   <= cnt + 1'b1;
               // Unload during the first shift after reset/drain is stale and dropped.
               if (shift_done && (state == DRAIN || have_resp)) begin
                  resp_data  <= rx_nxt;
                  resp_valid <= 1'b1;
               end
               if (shift_done && state == DRAIN) begin
                  have_resp  <= 1'b0;
                  drain_pend <= 1'b0;
               end
            end
            CAPTURE: begin
               have_resp <= 1'b1;
               cap_q     <= cap_q + 16'd1;
               if (last) drain_pend <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
